// File: rtl/fifo_ptr_pkg.sv
// Gray/binary pointer helpers shared by the dual-clock FIFO pointer blocks.
// Pointers are PTR_W = add_size+1 bits wide; helpers operate on a MAX_PTR_W-bit container.
package fifo_ptr_pkg;

  localparam int unsigned MAX_PTR_W = 32;

  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Zero-extended Gray input decodes correctly since leading zeros propagate as zeros.
  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
    logic [MAX_PTR_W-1:0] b;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_w2r.sv
// Multi-flop synchroniser carrying the write-domain Gray pointer into rd_clk.
// No logic precedes the first flop.
module sync_w2r #(
  parameter int unsigned PTR_W       = 9,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] wr_ptr_sync
);

  logic [PTR_W-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= wr_ptr;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign wr_ptr_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rptr_empty.sv
// Read pointer (binary + Gray) and registered empty flag for the dual-clock FIFO.
// Define RD_LEVEL_EN to add the registered rd_level / almost_empty outputs.
module rptr_empty
  import fifo_ptr_pkg::*;
#(
  parameter int unsigned add_size    = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AE_THRESH   = 4
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  input  logic                rd_inc,
  input  logic [add_size:0]   wr_ptr,
  output logic [add_size-1:0] rd_addr,
  output logic [add_size:0]   rd_ptr,
  output logic                empty,
  output logic                rd_underflow,
  output logic [add_size:0]   rd_level,
  output logic                almost_empty
);

  localparam int unsigned PTR_W = add_size + 1;

  logic [PTR_W-1:0]     rbin_q, rbin_d;
  logic [PTR_W-1:0]     rgray_q, rgray_d;
  logic [PTR_W-1:0]     wr_ptr_sync;
  logic [MAX_PTR_W-1:0] gray_wide;
  logic                 empty_q, empty_d;
  logic                 underflow_q;

  sync_w2r #(
    .PTR_W      (PTR_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_w2r (
    .rd_clk     (rd_clk),
    .rd_rst     (rd_rst),
    .wr_ptr     (wr_ptr),
    .wr_ptr_sync(wr_ptr_sync)
  );

  // Comparing against the next Gray value lets empty rise on the edge that pops the last entry.
  always_comb begin
    rbin_d    = rbin_q + PTR_W'(rd_inc & ~empty_q);
    gray_wide = bin2gray(MAX_PTR_W'(rbin_d));
    rgray_d   = gray_wide[PTR_W-1:0];
    empty_d   = (rgray_d == wr_ptr_sync);
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rbin_q      <= '0;
      rgray_q     <= '0;
      empty_q     <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      rbin_q      <= rbin_d;
      rgray_q     <= rgray_d;
      empty_q     <= empty_d;
      underflow_q <= rd_inc & empty_q;
    end
  end

  assign rd_addr      = rbin_q[add_size-1:0];
  assign rd_ptr       = rgray_q;
  assign empty        = empty_q;
  assign rd_underflow = underflow_q;

`ifdef RD_LEVEL_EN
  logic [MAX_PTR_W-1:0] wbin_wide;
  logic [PTR_W-1:0]     level_d, level_q;
  logic                 ae_d, ae_q;
  logic                 unused_wide;

  // Level lags the true write pointer by the synchroniser delay, so it is pessimistic.
  always_comb begin
    wbin_wide = gray2bin(MAX_PTR_W'(wr_ptr_sync));
    level_d   = wbin_wide[PTR_W-1:0] - rbin_d;
    ae_d      = (level_d <= PTR_W'(AE_THRESH));
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      level_q <= '0;
      ae_q    <= 1'b1;
    end else begin
      level_q <= level_d;
      ae_q    <= ae_d;
    end
  end

  assign rd_level     = level_q;
  assign almost_empty = ae_q;
  assign unused_wide  = ^{gray_wide[MAX_PTR_W-1:PTR_W], wbin_wide[MAX_PTR_W-1:PTR_W]};
`else
  logic unused_wide;

  assign rd_level     = '0;
  assign almost_empty = empty_q;
  assign unused_wide  = ^gray_wide[MAX_PTR_W-1:PTR_W];
`endif

endmodule

// File: tb/tb_rptr_empty.sv
// Directed self-checking bench for rptr_empty (add_size=8, SYNC_STAGES=2, AE_THRESH=4).
module tb_rptr_empty;

  logic       rd_clk = 1'b0;
  logic       rd_rst;
  logic       rd_inc;
  logic [8:0] wr_ptr;
  logic [7:0] rd_addr;
  logic [8:0] rd_ptr;
  logic       empty;
  logic       rd_underflow;
  logic [8:0] rd_level;
  logic       almost_empty;

  int checks = 0;
  int errors = 0;

  rptr_empty #(
    .add_size   (8),
    .SYNC_STAGES(2),
    .AE_THRESH  (4)
  ) dut (
    .rd_clk      (rd_clk),
    .rd_rst      (rd_rst),
    .rd_inc      (rd_inc),
    .wr_ptr      (wr_ptr),
    .rd_addr     (rd_addr),
    .rd_ptr      (rd_ptr),
    .empty       (empty),
    .rd_underflow(rd_underflow),
    .rd_level    (rd_level),
    .almost_empty(almost_empty)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic edge_sample();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge rd_clk);
    rd_rst = 1'b1;
    rd_inc = 1'b0;
    wr_ptr = 9'h000;
    @(negedge rd_clk);
    rd_rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge rd_clk);
    rd_rst = 1'b1;
    rd_inc = 1'b1;
    wr_ptr = 9'h000;
    edge_sample();
    checks++;
    if ({empty, rd_ptr, rd_addr, rd_underflow} !== {1'b1, 9'h000, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset: empty=%b rd_ptr=%h rd_addr=%h unf=%b, want 1 000 00 0",
               empty, rd_ptr, rd_addr, rd_underflow);
    end
    checks++;
    if ({rd_level, almost_empty} !== {9'h000, 1'b1}) begin
      errors++;
      $display("FAIL reset_level: rd_level=%0d ae=%b, want 0 1", rd_level, almost_empty);
    end
    @(negedge rd_clk);
    rd_inc = 1'b0;
    rd_rst = 1'b0;
  endtask

  task automatic test_fill_and_pop();
    do_reset();
    @(negedge rd_clk);
    wr_ptr = 9'h002;  // Gray(3)
    for (int e = 1; e <= 3; e++) begin
      edge_sample();
      checks++;
      if (empty !== (e < 3)) begin
        errors++;
        $display("FAIL fill_latency edge %0d: empty=%b, want %b", e, empty, (e < 3));
      end
    end
    checks++;
    if (rd_addr !== 8'd0) begin
      errors++;
      $display("FAIL fill_addr0: rd_addr=%0d, want 0", rd_addr);
    end
    @(negedge rd_clk);
    rd_inc = 1'b1;
    for (int p = 1; p <= 3; p++) begin
      edge_sample();
      checks++;
      if (rd_addr !== 8'(p) || empty !== (p == 3)) begin
        errors++;
        $display("FAIL pop %0d: rd_addr=%0d empty=%b, want %0d %b", p, rd_addr, empty, p, (p == 3));
      end
    end
    checks++;
    if (rd_ptr !== 9'h002) begin
      errors++;
      $display("FAIL pop_gray: rd_ptr=%h, want 002", rd_ptr);
    end
    @(negedge rd_clk);
    rd_inc = 1'b0;
  endtask

  // Continues from the drained state left by test_fill_and_pop.
  task automatic test_underflow();
    @(negedge rd_clk);
    rd_inc = 1'b1;
    for (int c = 0; c < 2; c++) begin
      edge_sample();
      checks++;
      if (rd_underflow !== 1'b1 || rd_ptr !== 9'h002 || rd_addr !== 8'd3 || empty !== 1'b1) begin
        errors++;
        $display("FAIL underflow %0d: unf=%b rd_ptr=%h rd_addr=%0d empty=%b, want 1 002 3 1",
                 c, rd_underflow, rd_ptr, rd_addr, empty);
      end
    end
    @(negedge rd_clk);
    rd_inc = 1'b0;
    edge_sample();
    checks++;
    if (rd_underflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow_clear: unf=%b, want 0", rd_underflow);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge rd_clk);
    wr_ptr = 9'h180;  // Gray(256)
    repeat (3) edge_sample();
    checks++;
    if (empty !== 1'b0) begin
      errors++;
      $display("FAIL wrap_fill: empty=%b, want 0", empty);
    end
    @(negedge rd_clk);
    rd_inc = 1'b1;
    for (int p = 1; p <= 256; p++) begin
      edge_sample();
      if (p == 255) begin
        checks++;
        if (rd_addr !== 8'd255 || empty !== 1'b0) begin
          errors++;
          $display("FAIL wrap_255: rd_addr=%0d empty=%b, want 255 0", rd_addr, empty);
        end
      end
    end
    checks++;
    if (rd_ptr !== 9'h180 || rd_addr !== 8'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_end: rd_ptr=%h rd_addr=%0d empty=%b, want 180 0 1",
               rd_ptr, rd_addr, empty);
    end
    @(negedge rd_clk);
    rd_inc = 1'b0;
  endtask

  task automatic test_midop_reset();
    do_reset();
    @(negedge rd_clk);
    wr_ptr = 9'h00F;  // Gray(10)
    repeat (3) edge_sample();
    @(negedge rd_clk);
    rd_inc = 1'b1;
    repeat (5) edge_sample();
    checks++;
    if (rd_addr !== 8'd5 || rd_ptr !== 9'h007 || empty !== 1'b0) begin
      errors++;
      $display("FAIL midop_pre: rd_addr=%0d rd_ptr=%h empty=%b, want 5 007 0",
               rd_addr, rd_ptr, empty);
    end
    rd_rst = 1'b1;
    wr_ptr = 9'h000;
    #1;
    checks++;
    if ({empty, rd_ptr, rd_addr, rd_underflow, rd_level, almost_empty}
        !== {1'b1, 9'h000, 8'h00, 1'b0, 9'h000, 1'b1}) begin
      errors++;
      $display("FAIL midop_reset: empty=%b rd_ptr=%h rd_addr=%0d unf=%b lvl=%0d ae=%b",
               empty, rd_ptr, rd_addr, rd_underflow, rd_level, almost_empty);
    end
    @(negedge rd_clk);
    rd_inc = 1'b0;
    rd_rst = 1'b0;
  endtask

  task automatic test_level();
    do_reset();
    @(negedge rd_clk);
    wr_ptr = 9'h005;  // Gray(6)
    repeat (4) edge_sample();
`ifdef RD_LEVEL_EN
    checks++;
    if (rd_level !== 9'd6 || almost_empty !== 1'b0) begin
      errors++;
      $display("FAIL level_6: rd_level=%0d ae=%b, want 6 0", rd_level, almost_empty);
    end
`else
    checks++;
    if (rd_level !== 9'd0 || almost_empty !== 1'b0 || empty !== 1'b0) begin
      errors++;
      $display("FAIL level_tied: rd_level=%0d ae=%b empty=%b, want 0 0 0",
               rd_level, almost_empty, empty);
    end
`endif
    @(negedge rd_clk);
    rd_inc = 1'b1;
    repeat (2) edge_sample();
    @(negedge rd_clk);
    rd_inc = 1'b0;
`ifdef RD_LEVEL_EN
    checks++;
    if (rd_level !== 9'd4 || almost_empty !== 1'b1) begin
      errors++;
      $display("FAIL level_4: rd_level=%0d ae=%b, want 4 1", rd_level, almost_empty);
    end
`else
    checks++;
    if (rd_level !== 9'd0 || almost_empty !== 1'b0 || rd_addr !== 8'd2) begin
      errors++;
      $display("FAIL level_tied_pop: rd_level=%0d ae=%b rd_addr=%0d, want 0 0 2",
               rd_level, almost_empty, rd_addr);
    end
`endif
  endtask

  initial begin
    rd_rst = 1'b1;
    rd_inc = 1'b0;
    wr_ptr = 9'h000;
    test_reset();
    test_fill_and_pop();
    test_underflow();
    test_wrap();
    test_midop_reset();
    test_level();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
